or1200_ic_fetchq: RTL and testbench

OR1200_IC_FETCHQ -- requirements
Module: or1200_ic_fetchq

---
 rtl/or1200_ic_fetchq_if.sv | 25 ++
 rtl/or1200_ic_fetchq.sv | 110 +++++++++++
 tb/tb_or1200_ic_fetchq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/or1200_ic_fetchq_if.sv
// Fetch-queue bus: IC RAM read port, redirect request and decode-side instruction handshake.
// The fetch queue connects through the slave modport; its environment drives the master side.
interface or1200_ic_fetchq_if #(
   parameter int aw = 11
);
   logic          ic_en;
   logic [aw-1:0] ic_addr;
   logic [63:0]   ic_dataout;
   logic          redirect;
   logic [aw:0]   redirect_addr;
   logic          insn_valid;
   logic [31:0]   insn;
   logic [aw:0]   insn_addr;
   logic          insn_ready;

   modport slave (
      output ic_en, ic_addr, insn_valid, insn, insn_addr,
      input  ic_dataout, redirect, redirect_addr, insn_ready
   );

   modport master (
      input  ic_en, ic_addr, insn_valid, insn, insn_addr,
      output ic_dataout, redirect, redirect_addr, insn_ready
   );
endinterface

// File: rtl/or1200_ic_fetchq.sv
// Instruction fetch queue: reads 64-bit IC lines, splits them into 32-bit words and
// buffers up to depth words ahead of decode; redirect flushes and restarts fetch.
module or1200_ic_fetchq #(
   parameter int aw    = 11,
   parameter int depth = 4
) (
   input  logic               clk,
   input  logic               rst,
   or1200_ic_fetchq_if.slave  bus
);

   localparam int pw = (depth > 1) ? $clog2(depth) : 1;
   localparam int sw = $clog2(depth + 3);
   localparam logic [sw-1:0] occ_lim = sw'(depth - 2);

   typedef struct packed {
      logic [aw:0]  addr;
      logic [31:0]  data;
   } entry_t;

   entry_t        mem [depth];
   logic [pw-1:0] rd_ptr, rd_ptr_n;
   logic [pw-1:0] wr_ptr, wr_ptr_n, wr_ptr1;
   logic [sw-1:0] count, count_n;
   logic [1:0]    pending, pending_n;
   logic [aw:0]   fptr, fptr_n;
   logic [aw:0]   req_addr, req_addr_n;
   logic          issue;
   logic          pop;

   function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
      return (p == pw'(depth - 1)) ? '0 : p + pw'(1);
   endfunction

   // Reserving room for a whole line before issuing means returning data always fits.
   assign issue   = rst & ~bus.redirect & ((count + sw'(pending)) <= occ_lim);
   assign pop     = bus.insn_valid & bus.insn_ready & ~bus.redirect;
   assign wr_ptr1 = ptr_inc(wr_ptr);

   assign bus.ic_en      = issue;
   assign bus.ic_addr    = fptr[aw:1];
   assign bus.insn_valid = (count != '0);
   assign bus.insn       = mem[rd_ptr].data;
   assign bus.insn_addr  = mem[rd_ptr].addr;

   // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latch).
   always_comb begin
      rd_ptr_n   = rd_ptr;
      wr_ptr_n   = wr_ptr;
      count_n    = count;
      pending_n  = pending;
      fptr_n     = fptr;
      req_addr_n = req_addr;
      if (bus.redirect) begin
         rd_ptr_n  = '0;
         wr_ptr_n  = '0;
         count_n   = '0;
         pending_n = 2'd0;
         fptr_n    = bus.redirect_addr;
      end else begin
         if (pop)
            rd_ptr_n = ptr_inc(rd_ptr);
         case (pending)
            2'd1:    wr_ptr_n = wr_ptr1;
            2'd2:    wr_ptr_n = ptr_inc(wr_ptr1);
            default: wr_ptr_n = wr_ptr;
         endcase
         // Everything in flight lands this cycle, so pending is also the push count.
         count_n   = count + sw'(pending) - sw'(pop);
         pending_n = 2'd0;
         if (issue) begin
            pending_n  = fptr[0] ? 2'd1 : 2'd2;
            req_addr_n = fptr;
            fptr_n     = {fptr[aw:1] + aw'(1), 1'b0};
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         pending  <= 2'd0;
         fptr     <= '0;
         req_addr <= '0;
      end else begin
         rd_ptr   <= rd_ptr_n;
         wr_ptr   <= wr_ptr_n;
         count    <= count_n;
         pending  <= pending_n;
         fptr     <= fptr_n;
         req_addr <= req_addr_n;
      end
   end

   // NOTE: queue storage is not reset; count gates visibility so stale contents never escape.
   always_ff @(posedge clk) begin
      if (!bus.redirect && pending != 2'd0) begin
         mem[wr_ptr].addr <= req_addr;
         mem[wr_ptr].data <= req_addr[0] ? bus.ic_dataout[31:0] : bus.ic_dataout[63:32];
         if (pending == 2'd2) begin
            mem[wr_ptr1].addr <= {req_addr[aw:1], 1'b1};
            mem[wr_ptr1].data <= bus.ic_dataout[31:0];
         end
      end
   end

endmodule

// File: tb/tb_or1200_ic_fetchq.sv
// Bench for or1200_ic_fetchq: directed cycle tables, an async-reset sequence, and
// randomized ready/redirect traffic checked against a word-stream reference model.
module tb_or1200_ic_fetchq;

   localparam int aw    = 11;
   localparam int depth = 4;

   typedef struct {
      bit          restart;
      bit          rdr;
      logic [aw:0] raddr;
      bit          rdy;
      bit          en;
      logic [aw-1:0] ica;
      bit          v;
      logic [aw:0] ia;
   } vec_t;

   logic clk;
   logic rst;
   or1200_ic_fetchq_if #(.aw(aw)) bus ();

   or1200_ic_fetchq #(.aw(aw), .depth(depth)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests;
   int fails;
   vec_t vecs[$];

   logic          rd_valid;
   logic [aw-1:0] rd_line;
   logic [63:0]   garbage;

   int          outstanding, arriving, pops, r;
   bit          exp_en, exp_v, do_pop;
   logic [aw:0] next_req, exp_head;

   function automatic logic [31:0] word(input logic [aw:0] w);
      return 32'hC0DE_0000 | 32'(w);
   endfunction

   function automatic vec_t mk(bit restart, bit rdr, int raddr, bit rdy,
                               bit en, int ica, bit v, int ia);
      vec_t x;
      x.restart = restart;
      x.rdr     = rdr;
      x.raddr   = (aw+1)'(raddr);
      x.rdy     = rdy;
      x.en      = en;
      x.ica     = aw'(ica);
      x.v       = v;
      x.ia      = (aw+1)'(ia);
      return x;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // IC RAM model: a line read in one cycle is presented the next; otherwise junk.
   always @(posedge clk) begin
      rd_valid <= bus.ic_en;
      rd_line  <= bus.ic_addr;
      garbage  <= {$urandom, $urandom};
   end
   assign bus.ic_dataout = rd_valid ? {word({rd_line, 1'b0}), word({rd_line, 1'b1})} : garbage;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Leaves the bench just after a rising edge with rst released: the first fetch cycle.
   task automatic do_reset();
      rst               = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_addr = '0;
      bus.insn_ready    = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst               = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_addr = '0;
      bus.insn_ready    = 1'b0;
      #1;
      check("reset insn_valid", bus.insn_valid, 1'b0);
      check("reset ic_en", bus.ic_en, 1'b0);

      // streaming with ready held high
      vecs.push_back(mk(1,0,0,1, 1,0, 0,0));
      vecs.push_back(mk(0,0,0,1, 1,1, 0,0));
      vecs.push_back(mk(0,0,0,1, 0,2, 1,0));
      vecs.push_back(mk(0,0,0,1, 0,2, 1,1));
      vecs.push_back(mk(0,0,0,1, 1,2, 1,2));
      vecs.push_back(mk(0,0,0,1, 0,3, 1,3));
      vecs.push_back(mk(0,0,0,1, 1,3, 1,4));
      vecs.push_back(mk(0,0,0,1, 0,4, 1,5));
      vecs.push_back(mk(0,0,0,1, 1,4, 1,6));
      // fill with ready low, then drain
      vecs.push_back(mk(1,0,0,0, 1,0, 0,0));
      vecs.push_back(mk(0,0,0,0, 1,1, 0,0));
      vecs.push_back(mk(0,0,0,0, 0,2, 1,0));
      vecs.push_back(mk(0,0,0,0, 0,2, 1,0));
      vecs.push_back(mk(0,0,0,0, 0,2, 1,0));
      vecs.push_back(mk(0,0,0,1, 0,2, 1,0));
      vecs.push_back(mk(0,0,0,1, 0,2, 1,1));
      vecs.push_back(mk(0,0,0,1, 1,2, 1,2));
      vecs.push_back(mk(0,0,0,1, 0,3, 1,3));
      vecs.push_back(mk(0,0,0,1, 1,3, 1,4));
      vecs.push_back(mk(0,0,0,1, 0,4, 1,5));
      // redirect to an odd word
      vecs.push_back(mk(1,1,5,1, 0,0, 0,0));
      vecs.push_back(mk(0,0,0,1, 1,2, 0,0));
      vecs.push_back(mk(0,0,0,1, 1,3, 0,0));
      vecs.push_back(mk(0,0,0,1, 0,4, 1,5));
      vecs.push_back(mk(0,0,0,1, 1,4, 1,6));
      vecs.push_back(mk(0,0,0,1, 0,5, 1,7));
      // redirect while a read is in flight
      vecs.push_back(mk(1,0,0,1, 1,0, 0,0));
      vecs.push_back(mk(0,1,'h40,1, 0,1, 0,0));
      vecs.push_back(mk(0,0,0,1, 1,'h20, 0,0));
      vecs.push_back(mk(0,0,0,1, 1,'h21, 0,0));
      vecs.push_back(mk(0,0,0,1, 0,'h22, 1,'h40));
      vecs.push_back(mk(0,0,0,1, 0,'h22, 1,'h41));
      // address wrap
      vecs.push_back(mk(1,1,'hFFE,1, 0,0, 0,0));
      vecs.push_back(mk(0,0,0,1, 1,'h7FF, 0,0));
      vecs.push_back(mk(0,0,0,1, 1,0, 0,0));
      vecs.push_back(mk(0,0,0,1, 0,1, 1,'hFFE));
      vecs.push_back(mk(0,0,0,1, 0,1, 1,'hFFF));
      vecs.push_back(mk(0,0,0,1, 1,1, 1,0));
      vecs.push_back(mk(0,0,0,1, 0,2, 1,1));

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].restart) do_reset();
         else begin
            @(posedge clk); #1;
         end
         bus.redirect      = vecs[i].rdr;
         bus.redirect_addr = vecs[i].raddr;
         bus.insn_ready    = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("vec%0d ic_en", i), bus.ic_en, vecs[i].en);
         check($sformatf("vec%0d ic_addr", i), bus.ic_addr, vecs[i].ica);
         check($sformatf("vec%0d insn_valid", i), bus.insn_valid, vecs[i].v);
         if (vecs[i].v) begin
            check($sformatf("vec%0d insn_addr", i), bus.insn_addr, vecs[i].ia);
            check($sformatf("vec%0d insn", i), bus.insn, word(vecs[i].ia));
         end
      end

      // asynchronous reset between edges with three words queued
      do_reset();
      @(negedge clk);
      check("ar c0 ic_en", bus.ic_en, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.insn_ready = 1'b1;
      @(posedge clk); #1;
      bus.insn_ready = 1'b0;
      @(negedge clk);
      check("ar queued valid", bus.insn_valid, 1'b1);
      check("ar queued head", bus.insn_addr, 12'd1);
      #2 rst = 1'b0;
      #1;
      check("ar insn_valid", bus.insn_valid, 1'b0);
      check("ar ic_en", bus.ic_en, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("ar restart ic_en", bus.ic_en, 1'b1);
      check("ar restart ic_addr", bus.ic_addr, 11'd0);
      check("ar restart valid", bus.insn_valid, 1'b0);
      @(posedge clk); #1;
      bus.insn_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("ar first valid", bus.insn_valid, 1'b1);
      check("ar first addr", bus.insn_addr, 12'd0);
      check("ar first insn", bus.insn, word(12'd0));

      // randomized traffic against a word-stream model
      do_reset();
      outstanding = 0;
      arriving    = 0;
      pops        = 0;
      next_req    = '0;
      exp_head    = '0;
      for (int c = 0; c < 3000; c++) begin
         r = int'($urandom_range(99));
         bus.insn_ready = (r < 70);
         bus.redirect   = ($urandom_range(99) < 3);
         if ($urandom_range(1) == 1) bus.redirect_addr = (aw+1)'($urandom);
         else bus.redirect_addr = (aw+1)'(32'hFFC + $urandom_range(3));
         @(negedge clk);
         exp_en = !bus.redirect && (outstanding <= depth - 2);
         exp_v  = (outstanding - arriving) > 0;
         check($sformatf("rnd%0d ic_en", c), bus.ic_en, exp_en);
         if (exp_en) check($sformatf("rnd%0d ic_addr", c), bus.ic_addr, next_req[aw:1]);
         check($sformatf("rnd%0d insn_valid", c), bus.insn_valid, exp_v);
         if (exp_v) begin
            check($sformatf("rnd%0d insn_addr", c), bus.insn_addr, exp_head);
            check($sformatf("rnd%0d insn", c), bus.insn, word(exp_head));
         end
         if (bus.redirect) begin
            outstanding = 0;
            arriving    = 0;
            next_req    = bus.redirect_addr;
            exp_head    = bus.redirect_addr;
         end else begin
            do_pop   = exp_v && bus.insn_ready;
            arriving = exp_en ? (next_req[0] ? 1 : 2) : 0;
            outstanding = outstanding + arriving - (do_pop ? 1 : 0);
            if (exp_en) next_req = ((next_req >> 1) + 1'b1) << 1;
            if (do_pop) begin
               exp_head = exp_head + 1'b1;
               pops++;
            end
         end
         @(posedge clk); #1;
      end
      bus.redirect = 1'b0;
      check("rnd progress", (pops > 200), 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
